// File: rtl/cache_sa_lru_model_pkg.sv
// Shared types and derived-width helpers for the set-associative cache tag model.
// The optional write-back behaviour is controlled by the CACHE_WRITEBACK_EN macro.
package cache_sim_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int DEF_ADDR_W      = 31;
    localparam int DEF_CACHE_BYTES = 8192;
    localparam int DEF_LINE_BYTES  = 8;
    localparam int DEF_ASSOC       = 4;
    localparam int DEF_CNT_W       = 32;

    function automatic int sets_f(input int cache_bytes, input int line_bytes, input int assoc);
        return cache_bytes / (line_bytes * assoc);
    endfunction

    function automatic int off_w_f(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    // Zero is a legal result: a single set means fully associative.
    function automatic int idx_w_f(input int cache_bytes, input int line_bytes, input int assoc);
        return $clog2(sets_f(cache_bytes, line_bytes, assoc));
    endfunction

    function automatic int way_w_f(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

endpackage

// File: rtl/cache_sa_lru_model_if.sv
// Request/response bundle between the trace driver and the cache tag model.
// The response fields are qualified by resp_valid_41.
interface cache_sa_lru_model_if #(
    parameter int ADDR_W = 31,
    parameter int WAY_W  = 2
);
    logic              req_valid_41;
    logic              req_ready_41;
    logic [ADDR_W-1:0] req_addr_41;
    logic              req_we_41;
    logic              resp_valid_41;
    logic              resp_hit_41;
    logic [WAY_W-1:0]  resp_way_41;
    logic              resp_evict_41;
    logic              resp_wb_41;

    modport master (
        output req_valid_41, req_addr_41, req_we_41,
        input  req_ready_41, resp_valid_41, resp_hit_41, resp_way_41, resp_evict_41, resp_wb_41
    );

    modport slave (
        input  req_valid_41, req_addr_41, req_we_41,
        output req_ready_41, resp_valid_41, resp_hit_41, resp_way_41, resp_evict_41, resp_wb_41
    );
endinterface

// File: rtl/cache_sa_lru_model_lru_rank.sv
// True-LRU rank update for one set: touching a way promotes it to MRU (ASSOC-1)
// and closes the gap it leaves. Also reports the rank-0 (least recent) way.
module cache_lru_rank #(
    parameter int ASSOC = 4,
    parameter int WAY_W = 2
) (
    input  logic [ASSOC-1:0][WAY_W-1:0] rank_in,
    input  logic [WAY_W-1:0]            touch_way,
    output logic [ASSOC-1:0][WAY_W-1:0] rank_out,
    output logic [WAY_W-1:0]            victim
);

    logic [WAY_W-1:0] touch_rank;

    // Promote the touched way; ways ranked above it slide down by one.
    always_comb begin
        touch_rank = '0;
        for (int w = 0; w < ASSOC; w++)
            if (WAY_W'(w) == touch_way) touch_rank = rank_in[w];
        rank_out = rank_in;
        for (int w = 0; w < ASSOC; w++) begin
            if (WAY_W'(w) == touch_way)       rank_out[w] = WAY_W'(ASSOC - 1);
            else if (rank_in[w] > touch_rank) rank_out[w] = rank_in[w] - 1'b1;
        end
    end

    // Ranks form a permutation, so exactly one way holds rank 0.
    always_comb begin
        victim = '0;
        for (int w = 0; w < ASSOC; w++)
            if (rank_in[w] == '0) victim = WAY_W'(w);
    end

endmodule

// File: rtl/cache_sa_lru_model.sv
// Set-associative cache tag/statistics model with true-LRU replacement.
// Define CACHE_WRITEBACK_EN for write-back/write-allocate; otherwise the
// model is write-through/no-write-allocate with no dirty state.
module cache_sa_lru_model
    import cache_sim_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int CACHE_BYTES = DEF_CACHE_BYTES,
    parameter int LINE_BYTES  = DEF_LINE_BYTES,
    parameter int ASSOC       = DEF_ASSOC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                  clk_41,
    input  logic                  rst_41,
    cache_sa_lru_model_if.slave   bus,
    input  logic                  flush_41,
    output logic                  busy_41,
    output logic [CNT_W-1:0]      hits_41,
    output logic [CNT_W-1:0]      misses_41,
    output logic [CNT_W-1:0]      evicts_41,
    output logic [CNT_W-1:0]      wbacks_41
);

    localparam int SETS   = sets_f(CACHE_BYTES, LINE_BYTES, ASSOC);
    localparam int OFF_W  = off_w_f(LINE_BYTES);
    localparam int IDX_W  = idx_w_f(CACHE_BYTES, LINE_BYTES, ASSOC);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W  = way_w_f(ASSOC);
    localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;

    state_t state_q, state_d;
    logic [IDX_WS-1:0] ptr_q;
    logic              sweep_last;

    logic [TAG_W-1:0]             tag_q   [SETS][ASSOC];
    logic [ASSOC-1:0]             valid_q [SETS];
    logic [ASSOC-1:0][WAY_W-1:0]  rank_q  [SETS];
`ifdef CACHE_WRITEBACK_EN
    logic [ASSOC-1:0]             dirty_q [SETS];
`endif

    logic [IDX_WS-1:0] set_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              accept, hit, alloc, touch, evict, wback;
    logic [ASSOC-1:0]  hit_vec;
    logic [WAY_W-1:0]  hit_way, victim, touch_way;
    logic [ASSOC-1:0][WAY_W-1:0] rank_cur, rank_nxt;

    logic             resp_valid_q, resp_hit_q, resp_evict_q, resp_wb_q;
    logic [WAY_W-1:0] resp_way_q;

    generate
        if (IDX_W > 0) begin : g_idx
            assign set_idx = bus.req_addr_41[OFF_W +: IDX_WS];
        end else begin : g_noidx
            assign set_idx = '0;
        end
        if (OFF_W > 0) begin : g_off
            logic unused_off;
            assign unused_off = ^bus.req_addr_41[OFF_W-1:0];
        end
    endgenerate
    assign req_tag    = bus.req_addr_41[ADDR_W-1 -: TAG_W];
    assign sweep_last = (ptr_q == IDX_WS'(SETS - 1));

    // State register.
    always_ff @(posedge clk_41 or negedge rst_41) begin
        if (!rst_41) state_q <= ST_INIT;
        else         state_q <= state_d;
    end

    // Next state: sweeps run to the last set; flush wins over a same-cycle request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT, ST_FLUSH: if (sweep_last) state_d = ST_IDLE;
            ST_IDLE:           if (flush_41)   state_d = ST_FLUSH;
            default:           state_d = ST_INIT;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.req_ready_41 = (state_q == ST_IDLE) && !flush_41;
        busy_41          = (state_q == ST_INIT) || (state_q == ST_FLUSH);
    end

    // Sweep pointer walks every set once and parks at 0 for the next sweep.
    always_ff @(posedge clk_41 or negedge rst_41) begin
        if (!rst_41)      ptr_q <= '0;
        else if (busy_41) ptr_q <= sweep_last ? '0 : ptr_q + 1'b1;
    end

    assign accept   = bus.req_valid_41 && bus.req_ready_41;
    assign rank_cur = rank_q[set_idx];

    // Tag compare across the addressed set.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            hit_vec[w] = valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit = |hit_vec;
`ifdef CACHE_WRITEBACK_EN
    assign alloc = !hit;
    assign wback = evict && dirty_q[set_idx][victim];
`else
    assign alloc = !hit && !bus.req_we_41;
    assign wback = 1'b0;
`endif
    assign touch     = hit || alloc;
    assign touch_way = hit ? hit_way : victim;
    assign evict     = alloc && valid_q[set_idx][victim];

    cache_lru_rank #(.ASSOC(ASSOC), .WAY_W(WAY_W)) u_lru (
        .rank_in  (rank_cur),
        .touch_way(touch_way),
        .rank_out (rank_nxt),
        .victim   (victim)
    );

    // Tag store: sweeps clear one set per cycle, accesses update the addressed set.
    always_ff @(posedge clk_41) begin
        if (busy_41) begin
            valid_q[ptr_q] <= '0;
            for (int w = 0; w < ASSOC; w++) rank_q[ptr_q][w] <= WAY_W'(w);
`ifdef CACHE_WRITEBACK_EN
            dirty_q[ptr_q] <= '0;
`endif
        end else if (accept && touch) begin
            rank_q[set_idx] <= rank_nxt;
            if (alloc) begin
                tag_q[set_idx][victim]   <= req_tag;
                valid_q[set_idx][victim] <= 1'b1;
            end
`ifdef CACHE_WRITEBACK_EN
            if (bus.req_we_41)  dirty_q[set_idx][touch_way] <= 1'b1;
            else if (alloc)     dirty_q[set_idx][victim]    <= 1'b0;
`endif
        end
    end

    // Registered response, one cycle after accept.
    always_ff @(posedge clk_41 or negedge rst_41) begin
        if (!rst_41) begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_evict_q <= 1'b0;
            resp_wb_q    <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            if (accept) begin
                resp_hit_q   <= hit;
                resp_way_q   <= hit ? hit_way : (alloc ? victim : '0);
                resp_evict_q <= evict;
                resp_wb_q    <= wback;
            end
        end
    end

    assign bus.resp_valid_41 = resp_valid_q;
    assign bus.resp_hit_41   = resp_hit_q;
    assign bus.resp_way_41   = resp_way_q;
    assign bus.resp_evict_41 = resp_evict_q;
    assign bus.resp_wb_41    = resp_wb_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + 1'b1 : v;
    endfunction

    // Saturating access statistics; a flush leaves them untouched.
    always_ff @(posedge clk_41 or negedge rst_41) begin
        if (!rst_41) begin
            hits_41   <= '0;
            misses_41 <= '0;
            evicts_41 <= '0;
        end else if (accept) begin
            hits_41   <= sat_inc(hits_41, hit);
            misses_41 <= sat_inc(misses_41, !hit);
            evicts_41 <= sat_inc(evicts_41, evict);
        end
    end

`ifdef CACHE_WRITEBACK_EN
    localparam int SUM_W = CNT_W + WAY_W + 1;
    logic [SUM_W-1:0] flush_pop, wb_sum;

    // Dirty lines in the set being flushed this cycle.
    always_comb begin
        flush_pop = '0;
        if (state_q == ST_FLUSH)
            for (int w = 0; w < ASSOC; w++)
                flush_pop = flush_pop + SUM_W'(valid_q[ptr_q][w] && dirty_q[ptr_q][w]);
    end

    assign wb_sum = SUM_W'(wbacks_41) + flush_pop + SUM_W'(accept && wback);

    // Write-back counter: eviction write-backs plus flushed dirty lines, saturating.
    always_ff @(posedge clk_41 or negedge rst_41) begin
        if (!rst_41) wbacks_41 <= '0;
        else         wbacks_41 <= (wb_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : wb_sum[CNT_W-1:0];
    end
`else
    assign wbacks_41 = '0;
`endif

endmodule

// File: tb/tb_cache_sa_lru_model.sv
// Directed bench for cache_sa_lru_model (default geometry: 256 sets x 4 ways,
// set-0 aliases at stride 0x800). A second instance with CNT_W=4 covers saturation.
module tb_cache_sa_lru_model;
    localparam int ADDR_W = 31;
    localparam int WAY_W  = 2;
    localparam int CNT_W  = 32;
    localparam int SCNT_W = 4;

    logic clk_41 = 1'b0;
    logic rst_41 = 1'b0;
    logic flush_41 = 1'b0;
    logic sflush_41 = 1'b0;
    logic busy_41, sbusy_41;
    logic [CNT_W-1:0]  hits_41, misses_41, evicts_41, wbacks_41;
    logic [SCNT_W-1:0] shits_41, smisses_41, sevicts_41, swbacks_41;

    int n_checks = 0;
    int n_fail   = 0;

    logic             r_valid, r_hit, r_evict, r_wb;
    logic [WAY_W-1:0] r_way;

    cache_sa_lru_model_if #(.ADDR_W(ADDR_W), .WAY_W(WAY_W)) bus ();
    cache_sa_lru_model_if #(.ADDR_W(ADDR_W), .WAY_W(WAY_W)) sbus ();

    cache_sa_lru_model #(.ADDR_W(ADDR_W), .CACHE_BYTES(8192), .LINE_BYTES(8), .ASSOC(4), .CNT_W(CNT_W)) dut (
        .clk_41(clk_41), .rst_41(rst_41), .bus(bus), .flush_41(flush_41), .busy_41(busy_41),
        .hits_41(hits_41), .misses_41(misses_41), .evicts_41(evicts_41), .wbacks_41(wbacks_41)
    );

    cache_sa_lru_model #(.ADDR_W(ADDR_W), .CACHE_BYTES(8192), .LINE_BYTES(8), .ASSOC(4), .CNT_W(SCNT_W)) dut_sat (
        .clk_41(clk_41), .rst_41(rst_41), .bus(sbus), .flush_41(sflush_41), .busy_41(sbusy_41),
        .hits_41(shits_41), .misses_41(smisses_41), .evicts_41(sevicts_41), .wbacks_41(swbacks_41)
    );

    always #5 clk_41 = ~clk_41;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One access on the main DUT; the response is captured 1ns after the accepting edge.
    task automatic access(input logic [ADDR_W-1:0] a, input logic we);
        @(negedge clk_41);
        bus.req_valid_41 = 1'b1;
        bus.req_addr_41  = a;
        bus.req_we_41    = we;
        @(posedge clk_41);
        #1;
        bus.req_valid_41 = 1'b0;
        r_valid = bus.resp_valid_41;
        r_hit   = bus.resp_hit_41;
        r_way   = bus.resp_way_41;
        r_evict = bus.resp_evict_41;
        r_wb    = bus.resp_wb_41;
    endtask

    // Counts negedges on which busy_41 is high; call at a negedge.
    task automatic count_busy(output int n);
        n = 0;
        while (busy_41 === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk_41);
        end
    endtask

    task automatic do_flush();
        int n;
        @(negedge clk_41);
        flush_41 = 1'b1;
        @(negedge clk_41);
        flush_41 = 1'b0;
        count_busy(n);
    endtask

    task automatic test_reset();
        int n;
        bus.req_valid_41 = 1'b0; bus.req_addr_41 = '0; bus.req_we_41 = 1'b0;
        sbus.req_valid_41 = 1'b0; sbus.req_addr_41 = '0; sbus.req_we_41 = 1'b0;
        rst_41 = 1'b0;
        repeat (3) @(negedge clk_41);
        #1;
        n_checks++; if (hits_41 !== 0)   begin n_fail++; $display("FAIL rst_hits: got %0d exp 0", hits_41); end
        n_checks++; if (misses_41 !== 0) begin n_fail++; $display("FAIL rst_misses: got %0d exp 0", misses_41); end
        n_checks++; if (evicts_41 !== 0) begin n_fail++; $display("FAIL rst_evicts: got %0d exp 0", evicts_41); end
        n_checks++; if (wbacks_41 !== 0) begin n_fail++; $display("FAIL rst_wbacks: got %0d exp 0", wbacks_41); end
        n_checks++; if (bus.resp_valid_41 !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %0b exp 0", bus.resp_valid_41); end
        n_checks++; if (bus.req_ready_41 !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b exp 0", bus.req_ready_41); end
        n_checks++; if (busy_41 !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %0b exp 1", busy_41); end
        @(negedge clk_41);
        rst_41 = 1'b1;
        count_busy(n);
        n_checks++; if (n !== 256) begin n_fail++; $display("FAIL init_cycles: got %0d exp 256", n); end
        n_checks++; if (bus.req_ready_41 !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %0b exp 1", bus.req_ready_41); end
    endtask

    task automatic test_basic();
        access(31'h0, 1'b0);
        n_checks++; if (r_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %0b exp 1", r_valid); end
        n_checks++; if (r_hit !== 1'b0)   begin n_fail++; $display("FAIL t1_first_hit: got %0b exp 0", r_hit); end
        access(31'h4, 1'b0);
        n_checks++; if (r_hit !== 1'b1) begin n_fail++; $display("FAIL t1_second_hit: got %0b exp 1", r_hit); end
        n_checks++; if (r_way !== 2'd0) begin n_fail++; $display("FAIL t1_way: got %0d exp 0", r_way); end
        n_checks++; if (hits_41 !== 1)   begin n_fail++; $display("FAIL t1_hits: got %0d exp 1", hits_41); end
        n_checks++; if (misses_41 !== 1) begin n_fail++; $display("FAIL t1_misses: got %0d exp 1", misses_41); end
    endtask

    task automatic test_lru();
        access(31'h0, 1'b0);
        access(31'h800, 1'b0);
        n_checks++; if (r_way !== 2'd1) begin n_fail++; $display("FAIL lru_fill_way: got %0d exp 1", r_way); end
        access(31'h1000, 1'b0);
        access(31'h1800, 1'b0);
        n_checks++; if (r_evict !== 1'b0) begin n_fail++; $display("FAIL lru_fill_evict: got %0b exp 0", r_evict); end
        access(31'h0, 1'b0);
        access(31'h2000, 1'b0);
        n_checks++; if (r_hit !== 1'b0)   begin n_fail++; $display("FAIL lru_victim_hit: got %0b exp 0", r_hit); end
        n_checks++; if (r_evict !== 1'b1) begin n_fail++; $display("FAIL lru_evict: got %0b exp 1", r_evict); end
        n_checks++; if (r_way !== 2'd1)   begin n_fail++; $display("FAIL lru_victim_way: got %0d exp 1", r_way); end
        n_checks++; if (evicts_41 !== 1)  begin n_fail++; $display("FAIL lru_evicts: got %0d exp 1", evicts_41); end
        access(31'h0, 1'b0);
        n_checks++; if (r_hit !== 1'b1) begin n_fail++; $display("FAIL lru_keep_mru: got %0b exp 1", r_hit); end
        n_checks++; if (hits_41 !== 4)   begin n_fail++; $display("FAIL lru_hits: got %0d exp 4", hits_41); end
        n_checks++; if (misses_41 !== 5) begin n_fail++; $display("FAIL lru_misses: got %0d exp 5", misses_41); end
    endtask

    task automatic test_flush();
        int n;
        @(negedge clk_41);
        flush_41 = 1'b1;
        bus.req_valid_41 = 1'b1; bus.req_addr_41 = 31'h0; bus.req_we_41 = 1'b0;
        #1;
        n_checks++; if (bus.req_ready_41 !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b exp 0", bus.req_ready_41); end
        @(posedge clk_41);
        #1;
        n_checks++; if (bus.resp_valid_41 !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %0b exp 0", bus.resp_valid_41); end
        flush_41 = 1'b0;
        bus.req_valid_41 = 1'b0;
        @(negedge clk_41);
        count_busy(n);
        n_checks++; if (n !== 256) begin n_fail++; $display("FAIL flush_cycles: got %0d exp 256", n); end
        access(31'h0, 1'b0);
        n_checks++; if (r_hit !== 1'b0)   begin n_fail++; $display("FAIL flush_miss: got %0b exp 0", r_hit); end
        n_checks++; if (r_evict !== 1'b0) begin n_fail++; $display("FAIL flush_evict: got %0b exp 0", r_evict); end
        n_checks++; if (hits_41 !== 4)    begin n_fail++; $display("FAIL flush_hits_kept: got %0d exp 4", hits_41); end
        n_checks++; if (misses_41 !== 6)  begin n_fail++; $display("FAIL flush_misses: got %0d exp 6", misses_41); end
    endtask

    task automatic test_write_policy();
        do_flush();
`ifdef CACHE_WRITEBACK_EN
        access(31'h0, 1'b1);
        n_checks++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL wb_write_miss: got %0b exp 0", r_hit); end
        access(31'h800, 1'b0);
        access(31'h1000, 1'b0);
        access(31'h1800, 1'b0);
        access(31'h2000, 1'b0);
        n_checks++; if (r_wb !== 1'b1)    begin n_fail++; $display("FAIL wb_resp_wb: got %0b exp 1", r_wb); end
        n_checks++; if (r_way !== 2'd0)   begin n_fail++; $display("FAIL wb_victim_way: got %0d exp 0", r_way); end
        n_checks++; if (wbacks_41 !== 1)  begin n_fail++; $display("FAIL wb_wbacks: got %0d exp 1", wbacks_41); end
        access(31'h8, 1'b1);
        do_flush();
        n_checks++; if (wbacks_41 !== 2)  begin n_fail++; $display("FAIL wb_flush_wbacks: got %0d exp 2", wbacks_41); end
`else
        access(31'h0, 1'b1);
        n_checks++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL wt_write_miss: got %0b exp 0", r_hit); end
        n_checks++; if (r_way !== 2'd0) begin n_fail++; $display("FAIL wt_noalloc_way: got %0d exp 0", r_way); end
        n_checks++; if (misses_41 !== 7) begin n_fail++; $display("FAIL wt_misses: got %0d exp 7", misses_41); end
        access(31'h0, 1'b0);
        n_checks++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL wt_no_allocate: got %0b exp 0", r_hit); end
        access(31'h0, 1'b1);
        n_checks++; if (r_hit !== 1'b1) begin n_fail++; $display("FAIL wt_write_hit: got %0b exp 1", r_hit); end
        n_checks++; if (r_wb !== 1'b0)  begin n_fail++; $display("FAIL wt_resp_wb: got %0b exp 0", r_wb); end
        n_checks++; if (hits_41 !== 5)  begin n_fail++; $display("FAIL wt_hits: got %0d exp 5", hits_41); end
        n_checks++; if (wbacks_41 !== 0) begin n_fail++; $display("FAIL wt_wbacks: got %0d exp 0", wbacks_41); end
`endif
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_41);
            sbus.req_valid_41 = 1'b1;
            sbus.req_addr_41  = ADDR_W'(i * 8);
            sbus.req_we_41    = 1'b0;
            @(posedge clk_41);
            #1;
            sbus.req_valid_41 = 1'b0;
            if (i == 14) begin
                n_checks++; if (smisses_41 !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d exp 15", smisses_41); end
            end
        end
        n_checks++; if (smisses_41 !== 4'd15) begin n_fail++; $display("FAIL sat_misses: got %0d exp 15", smisses_41); end
        n_checks++; if (shits_41 !== 4'd0)    begin n_fail++; $display("FAIL sat_hits: got %0d exp 0", shits_41); end
    endtask

    task automatic test_reset_mid_flush();
        int n;
        @(negedge clk_41);
        flush_41 = 1'b1;
        @(negedge clk_41);
        flush_41 = 1'b0;
        repeat (10) @(negedge clk_41);
        #2;
        rst_41 = 1'b0;
        #1;
        n_checks++; if (hits_41 !== 0)   begin n_fail++; $display("FAIL arst_hits: got %0d exp 0", hits_41); end
        n_checks++; if (misses_41 !== 0) begin n_fail++; $display("FAIL arst_misses: got %0d exp 0", misses_41); end
        n_checks++; if (evicts_41 !== 0) begin n_fail++; $display("FAIL arst_evicts: got %0d exp 0", evicts_41); end
        n_checks++; if (smisses_41 !== 0) begin n_fail++; $display("FAIL arst_sat_misses: got %0d exp 0", smisses_41); end
        n_checks++; if (bus.resp_hit_41 !== 1'b0) begin n_fail++; $display("FAIL arst_resp_hit: got %0b exp 0", bus.resp_hit_41); end
        @(negedge clk_41);
        rst_41 = 1'b1;
        count_busy(n);
        n_checks++; if (n !== 256) begin n_fail++; $display("FAIL arst_init_cycles: got %0d exp 256", n); end
        access(31'h0, 1'b0);
        n_checks++; if (r_hit !== 1'b0)  begin n_fail++; $display("FAIL arst_cleared: got %0b exp 0", r_hit); end
        n_checks++; if (misses_41 !== 1) begin n_fail++; $display("FAIL arst_misses_after: got %0d exp 1", misses_41); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lru();
        test_flush();
        test_write_policy();
        test_saturation();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
